// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: load-use stall/bubble
// insertion, branch flush, WB-to-ID bypass and a saturating stall counter.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_s2,
  input  logic [31:0] pc_s2,
  input  logic [4:0]  rs1_s2,
  input  logic [4:0]  rs2_s2,
  input  logic [4:0]  rd_s2,
  input  logic        use_rs1_s2,
  input  logic        use_rs2_s2,
  input  logic [31:0] rs1_data_s2,
  input  logic [31:0] rs2_data_s2,
  input  logic [31:0] imm_s2,
  input  logic [3:0]  ALUSel_s2,
  input  logic [1:0]  WBSel_s2,
  input  logic        RegWEn_s2,
  input  logic        MemRead_s2,
  input  logic        MemWrite_s2,
  input  logic        flush_ex,
  input  logic        RegWEn_s5,
  input  logic [4:0]  rd_s5,
  input  logic [31:0] wb_data_s5,
  output logic        valid_s3,
  output logic [31:0] pc_s3,
  output logic [4:0]  rs1_s3,
  output logic [4:0]  rs2_s3,
  output logic [4:0]  rd_s3,
  output logic [31:0] rs1_data_s3,
  output logic [31:0] rs2_data_s3,
  output logic [31:0] imm_s3,
  output logic [3:0]  ALUSel_s3,
  output logic [1:0]  WBSel_s3,
  output logic        RegWEn_s3,
  output logic        MemRead_s3,
  output logic        MemWrite_s3,
  output logic        PCWEn,
  output logic        IFIDWEn,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_sel;
    logic [1:0]  wb_sel;
    logic        reg_wen;
    logic        mem_read;
    logic        mem_write;
  } ex_t;

  ex_t         ex_d, ex_q;
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic        lu, stall, byp1, byp2;

  always_comb begin
    lu = valid_s2 & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
         ((use_rs1_s2 & (rs1_s2 == ex_q.rd)) | (use_rs2_s2 & (rs2_s2 == ex_q.rd)));
    stall = lu & ~flush_ex;
    // Register file is read and written in the same cycle; take the WB value.
    byp1 = RegWEn_s5 & (rd_s5 != 5'd0) & (rd_s5 == rs1_s2);
    byp2 = RegWEn_s5 & (rd_s5 != 5'd0) & (rd_s5 == rs2_s2);

    ex_d = ex_q;
    if (flush_ex || stall) begin
      // Bubble: clear everything the forwarding unit or memory could act on.
      ex_d.valid     = 1'b0;
      ex_d.reg_wen   = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
      ex_d.rs1       = '0;
      ex_d.rs2       = '0;
      ex_d.rd        = '0;
    end else begin
      ex_d.valid     = valid_s2;
      ex_d.pc        = pc_s2;
      ex_d.rs1       = rs1_s2;
      ex_d.rs2       = rs2_s2;
      ex_d.rd        = rd_s2;
      ex_d.rs1_data  = byp1 ? wb_data_s5 : rs1_data_s2;
      ex_d.rs2_data  = byp2 ? wb_data_s5 : rs2_data_s2;
      ex_d.imm       = imm_s2;
      ex_d.alu_sel   = ALUSel_s2;
      ex_d.wb_sel    = WBSel_s2;
      ex_d.reg_wen   = RegWEn_s2;
      ex_d.mem_read  = MemRead_s2;
      ex_d.mem_write = MemWrite_s2;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PCWEn       = ~stall;
  assign IFIDWEn     = ~stall;
  assign stall_cnt   = stall_cnt_q;
  assign valid_s3    = ex_q.valid;
  assign pc_s3       = ex_q.pc;
  assign rs1_s3      = ex_q.rs1;
  assign rs2_s3      = ex_q.rs2;
  assign rd_s3       = ex_q.rd;
  assign rs1_data_s3 = ex_q.rs1_data;
  assign rs2_data_s3 = ex_q.rs2_data;
  assign imm_s3      = ex_q.imm;
  assign ALUSel_s3   = ex_q.alu_sel;
  assign WBSel_s3    = ex_q.wb_sel;
  assign RegWEn_s3   = ex_q.reg_wen;
  assign MemRead_s3  = ex_q.mem_read;
  assign MemWrite_s3 = ex_q.mem_write;

endmodule
